// File: rtl/tdm_digit_mux_n.sv
// -----------------------------------------------------------------------------
// tdm_digit_mux_n
// Time-division multiplexer for an N-digit seven-segment display. Each digit
// owns one slot of REFRESH_CYCLES clocks. The first BLANK_CYCLES clocks of every
// slot keep all anodes off, which avoids ghosting. The inputs are copied into
// shadow registers once per frame, so a display never shows a mix of two values.
// All outputs are registered and lag the slot timer/index by one clock.
//
// Optional build macro: TDM_LZ_BLANK_EN
//   When defined, leading zeros are suppressed at each shadow load. A digit is
//   suppressed when it holds BCD 0 and its decimal point is off. Suppression
//   starts at the top digit and stops at the first digit that is not suppressed.
//   Digit 0 is never suppressed.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous reset, active low
//   en           run enable; 0 freezes the scan and blanks all anodes
//   d_bus        BCD digits, digit i = d_bus[4*i+3:4*i], digit 0 rightmost
//   dp_in        decimal point per digit, 1 = lit
//   dig_en       per-digit enable, 0 = digit dark during its slot
//   digit        BCD code of the slot currently shown
//   dp_out       decimal point of the slot currently shown
//   an           anode drive, polarity set by ANODE_ACTIVE_LOW
//   frame_start  one-cycle pulse in the cycle after the shadow registers load
// -----------------------------------------------------------------------------
module tdm_digit_mux_n #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_CYCLES   = 50000,
  parameter int BLANK_CYCLES     = 0,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] d_bus,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [3:0]              digit,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TMR_W = $clog2(REFRESH_CYCLES);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  logic [TMR_W-1:0]        timer_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] shadow_d_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;
  logic [NUM_DIGITS-1:0]   shadow_en_r;
  logic                    loaded_r;

  phase_t                  phase_s;
  logic                    slot_last_s;
  logic                    load_s;
  logic [TMR_W-1:0]        timer_nxt_s;
  logic [IDX_W-1:0]        idx_nxt_s;
  logic [NUM_DIGITS-1:0]   onehot_s;
  logic [NUM_DIGITS-1:0]   an_nxt_s;
  logic [3:0]              digit_s;
  logic                    dp_s;
  logic [NUM_DIGITS-1:0]   shadow_en_in_s;

`ifdef TDM_LZ_BLANK_EN
  // Mask of digits kept lit after leading-zero suppression; bit 0 always kept.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(
    input logic [4*NUM_DIGITS-1:0] d,
    input logic [NUM_DIGITS-1:0]   dp
  );
    logic leading;
    lz_mask = {NUM_DIGITS{1'b1}};
    leading = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (leading && (d[4*i +: 4] == 4'd0) && !dp[i]) begin
        lz_mask[i] = 1'b0;
      end else begin
        leading = 1'b0;
      end
    end
  endfunction

  // Shadow enable source: per-digit enables combined with leading-zero mask
  always_comb begin
    shadow_en_in_s = dig_en & lz_mask(d_bus, dp_in);
  end
`else
  // Shadow enable source: per-digit enables used unchanged
  always_comb begin
    shadow_en_in_s = dig_en;
  end
`endif

  // Slot phase, counter advance and shadow-load decision
  always_comb begin
    phase_s     = PH_SHOW;
    timer_nxt_s = timer_r;
    idx_nxt_s   = idx_r;
    if (int'(timer_r) < BLANK_CYCLES) begin
      phase_s = PH_BLANK;
    end else begin
      phase_s = PH_SHOW;
    end
    slot_last_s = (timer_r == TMR_LAST);
    // The first enabled edge after reset also loads, so frame 0 has real data.
    load_s = en && (!loaded_r || (slot_last_s && (idx_r == IDX_LAST)));
    if (slot_last_s) begin
      timer_nxt_s = {TMR_W{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_nxt_s = {IDX_W{1'b0}};
      end else begin
        idx_nxt_s = idx_r + IDX_W'(1);
      end
    end else begin
      timer_nxt_s = timer_r + TMR_W'(1);
      idx_nxt_s   = idx_r;
    end
  end

  // Next output values derived from the current slot and shadow contents
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      onehot_s[i] = (idx_r == IDX_W'(i));
    end
    digit_s = shadow_d_r[{idx_r, 2'b00} +: 4];
    dp_s    = shadow_dp_r[idx_r];
    if ((phase_s == PH_SHOW) && shadow_en_r[idx_r]) begin
      an_nxt_s = (ANODE_ACTIVE_LOW != 0) ? ~onehot_s : onehot_s;
    end else begin
      an_nxt_s = AN_OFF;
    end
  end

  // Scan counters, shadow registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r     <= {TMR_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      shadow_d_r  <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r <= {NUM_DIGITS{1'b0}};
      shadow_en_r <= {NUM_DIGITS{1'b0}};
      loaded_r    <= 1'b0;
      digit       <= 4'd0;
      dp_out      <= 1'b0;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else if (en) begin
      timer_r <= timer_nxt_s;
      idx_r   <= idx_nxt_s;
      if (load_s) begin
        shadow_d_r  <= d_bus;
        shadow_dp_r <= dp_in;
        shadow_en_r <= shadow_en_in_s;
      end else begin
        shadow_d_r  <= shadow_d_r;
        shadow_dp_r <= shadow_dp_r;
        shadow_en_r <= shadow_en_r;
      end
      loaded_r    <= 1'b1;
      digit       <= digit_s;
      dp_out      <= dp_s;
      an          <= an_nxt_s;
      frame_start <= load_s;
    end else begin
      // Frozen: counters and shadows hold, anodes go dark.
      digit       <= digit_s;
      dp_out      <= dp_s;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_digit_mux_n.sv
module tb_tdm_digit_mux_n;

  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] d_bus;
  logic [3:0]  dp_in;
  logic [3:0]  dig_en;
  logic [3:0]  digit;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_start;
  logic [3:0]  digit3;
  logic        dp_out3;
  logic [2:0]  an3;
  logic        frame_start3;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] fd  [4];
  logic [3:0]  fen [4];
  logic        lz_on;

  tdm_digit_mux_n #(
    .NUM_DIGITS(4), .REFRESH_CYCLES(8), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .d_bus(d_bus), .dp_in(dp_in),
    .dig_en(dig_en), .digit(digit), .dp_out(dp_out), .an(an),
    .frame_start(frame_start)
  );

  tdm_digit_mux_n #(
    .NUM_DIGITS(3), .REFRESH_CYCLES(8), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .d_bus(d_bus[11:0]), .dp_in(dp_in[2:0]),
    .dig_en(dig_en[2:0]), .digit(digit3), .dp_out(dp_out3), .an(an3),
    .frame_start(frame_start3)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected active-low anode vector for a 4-digit slot under an enable mask.
  function automatic logic [3:0] exp_an(input int slot, input logic [3:0] mask);
    logic [3:0] oh;
    oh = 4'b0001 << slot;
    return mask[slot] ? ~oh : 4'hF;
  endfunction

  // Per-edge check of the main scan; k counts enabled edges from reset release.
  task automatic check_k(input int k);
    int f, s, t;
    logic [15:0] dv;
    logic [3:0]  exp_a;
    f  = (k - 1) / 32;
    s  = ((k - 1) / 8) % 4;
    t  = (k - 1) % 8;
    dv = fd[f];
    exp_a = (t >= B) ? exp_an(s, fen[f]) : 4'hF;
    chk($sformatf("an_k%0d", k), {12'd0, an}, {12'd0, exp_a});
    chk($sformatf("digit_k%0d", k), {12'd0, digit},
        (k == 1) ? 16'd0 : {12'd0, dv[4*s +: 4]});
    chk($sformatf("fs_k%0d", k), {15'd0, frame_start},
        {15'd0, ((k == 1) || (k % 32 == 0))});
  endtask

  initial begin
`ifdef TDM_LZ_BLANK_EN
    lz_on = 1'b1;
`else
    lz_on = 1'b0;
`endif
    fd[0] = 16'h4321; fen[0] = 4'hF;
    fd[1] = 16'h9876; fen[1] = 4'hF;
    fd[2] = 16'h9876; fen[2] = 4'b1011;
    fd[3] = 16'h9876; fen[3] = 4'b1011;

    // Reset state
    rst_n = 1'b0; en = 1'b0; d_bus = 16'h4321; dp_in = 4'h0; dig_en = 4'hF;
    repeat (3) tick();
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_digit", {12'd0, digit}, 16'h0000);
    chk("rst_dp", {15'd0, dp_out}, 16'h0000);
    chk("rst_fs", {15'd0, frame_start}, 16'h0000);
    chk("rst_an3", {13'd0, an3}, 16'h0007);

    // Three full frames: 4321, then 9876 (changed mid-frame), then dig_en=1011
    rst_n = 1'b1; en = 1'b1;
    for (int k = 1; k <= 108; k++) begin
      tick();
      check_k(k);
      if (k == 12) d_bus = 16'h9876;
      if (k == 40) dig_en = 4'b1011;
    end

    // Freeze mid slot 1 for 5 cycles, then resume the same slot
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("en0_an_%0d", i), {12'd0, an}, 16'h000F);
      chk($sformatf("en0_fs_%0d", i), {15'd0, frame_start}, 16'h0000);
    end
    en = 1'b1;
    for (int k = 109; k <= 120; k++) begin
      tick();
      check_k(k);
    end

    // Asynchronous reset between clock edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_an", {12'd0, an}, 16'h000F);
    chk("arst_digit", {12'd0, digit}, 16'h0000);
    chk("arst_fs", {15'd0, frame_start}, 16'h0000);
    chk("arst_an3", {13'd0, an3}, 16'h0007);

    // Restart from idx 0: 3-digit instance rotation and leading-zero frames
    d_bus = 16'h0050; dp_in = 4'h0; dig_en = 4'hF;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      int s, s3, t, f;
      logic [2:0] oh3;
      logic [3:0] mask;
      tick();
      s  = ((k - 1) / 8) % 4;
      s3 = ((k - 1) / 8) % 3;
      t  = (k - 1) % 8;
      f  = (k - 1) / 32;
      if (k <= 40) begin
        oh3 = 3'b001 << s3;
        chk($sformatf("an3_k%0d", k), {13'd0, an3},
            (k == 1) ? 16'h0007 : {13'd0, ~oh3});
      end
      if (t == 4) begin
        mask = (f == 0 && lz_on) ? 4'b0011 : 4'hF;
        chk($sformatf("lz_an_f%0d_s%0d", f, s), {12'd0, an}, {12'd0, exp_an(s, mask)});
        if (f == 0 && s == 1) chk("lz_digit5", {12'd0, digit}, 16'h0005);
        if (f == 1 && s == 3) begin
          chk("lz_dp3", {15'd0, dp_out}, 16'h0001);
          chk("lz_digit3", {12'd0, digit}, 16'h0000);
        end
      end
      if (k == 20) dp_in = 4'b1000;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
